// File: rtl/vqueue_serializer_pkg.sv
// Shared types and width-independent constants for the queue serializer.
// Optional feature macro used by this block: SERIALIZER_BYPASS_EN.
package vqueue_serializer_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_FLIT_WIDTH = 8;

  function automatic int unsigned idx_width_f(input int unsigned num_flits);
    return (num_flits <= 1) ? 1 : $clog2(num_flits);
  endfunction

endpackage

// File: rtl/vqueue_serializer_if.sv
// Upstream deq side and downstream enq side of the serializer, grouped as one bundle.
interface vqueue_serializer_if
  import vqueue_serializer_pkg::*;
#(
  parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
  parameter int unsigned flit_width = DEFAULT_FLIT_WIDTH
);
  logic                  deq_en;
  logic                  deq_rdy;
  logic [data_width-1:0] deq_msg;
  logic                  enq_en;
  logic                  enq_rdy;
  logic [flit_width-1:0] enq_msg;
  logic                  enq_last;

  modport master (
    output deq_en, input deq_rdy, input deq_msg,
    output enq_en, input enq_rdy, output enq_msg, output enq_last
  );

  modport slave (
    input deq_en, output deq_rdy, output deq_msg,
    input enq_en, output enq_rdy, input enq_msg, input enq_last
  );
endinterface

// File: rtl/vqueue_serializer_ctr.sv
// Flit index counter: clear (optionally straight to 1), increment, and last-flit flag.
module vqueue_serializer_ctr
  import vqueue_serializer_pkg::*;
#(
  parameter int unsigned num_flits = 4,
  localparam int unsigned idx_width = idx_width_f(num_flits)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [idx_width-1:0] idx,
  output logic                 last
);

  assign last = (idx == idx_width'(num_flits - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      // clear+inc starts a new message with flit 0 already sent
      idx <= (inc && (num_flits > 1)) ? idx_width'(1) : '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/vqueue_serializer.sv
// Drains wide messages from an upstream queue and emits them LSB-flit-first downstream.
// Optional macro SERIALIZER_BYPASS_EN: first flit passes straight through from deq_msg in IDLE.
module vqueue_serializer
  import vqueue_serializer_pkg::*;
#(
  parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
  parameter int unsigned flit_width = DEFAULT_FLIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  vqueue_serializer_if.master  q,
  output logic                 busy
);

  localparam int unsigned num_flits = data_width / flit_width;
  localparam int unsigned idx_width = idx_width_f(num_flits);

  if ((num_flits < 1) || (data_width % flit_width != 0)) begin : g_bad_widths
    $error("vqueue_serializer: data_width must be a positive multiple of flit_width");
  end

  ser_state_t state, state_d;
  logic [num_flits-1:0][flit_width-1:0] msg_q;
  logic [idx_width-1:0] idx;
  logic last, load, clr, inc;

  vqueue_serializer_ctr #(.num_flits(num_flits)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .inc   (inc),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      msg_q <= '0;
    end else begin
      state <= state_d;
      if (load) msg_q <= q.deq_msg;
    end
  end

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    clr        = 1'b0;
    inc        = 1'b0;
    q.deq_en   = 1'b0;
    q.enq_en   = 1'b0;
    q.enq_msg  = '0;
    q.enq_last = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          q.deq_en = q.deq_rdy;
          if (q.deq_rdy) begin
            load    = 1'b1;
            clr     = 1'b1;
            state_d = SEND;
          end
`ifdef SERIALIZER_BYPASS_EN
          if (q.deq_rdy && q.enq_rdy) begin
            q.enq_en   = 1'b1;
            q.enq_msg  = q.deq_msg[flit_width-1:0];
            q.enq_last = (num_flits == 1);
            if (num_flits == 1) begin
              load    = 1'b0;
              clr     = 1'b0;
              state_d = IDLE;
            end else begin
              inc = 1'b1;
            end
          end
`endif
        end
        SEND: begin
          q.enq_msg  = msg_q[idx];
          q.enq_last = last;
          q.enq_en   = q.enq_rdy;
          if (q.enq_rdy) begin
            if (!last) begin
              inc = 1'b1;
            end else begin
              // back-to-back reload keeps the link busy without a bubble
              q.deq_en = q.deq_rdy;
              if (q.deq_rdy) begin
                load = 1'b1;
                clr  = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = !reset && (state == SEND);

endmodule

// File: tb/tb_vqueue_serializer.sv
// Self-checking bench for vqueue_serializer (32-bit messages, 8-bit flits) with flit scoreboard.
module tb_vqueue_serializer;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  vqueue_serializer_if #(.data_width(32), .flit_width(8)) q ();

  vqueue_serializer #(.data_width(32), .flit_width(8)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .busy  (busy)
  );

  typedef struct {
    logic       enq_rdy;
    logic       deq_en;
    logic       enq_en;
    logic [7:0] msg;
    logic       last;
    logic       busy;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int flits_seen = 0;
  logic [7:0] first_flit, last_flit;

  logic rst_v = 1'b1;
  logic rdy_v = 1'b1;
  logic up_en = 1'b1;

  logic [31:0] up_q[$];
  logic [8:0]  exp_q[$];

  logic       s_deq_en, s_deq_rdy, s_enq_en, s_enq_last, s_busy;
  logic [7:0] s_enq_msg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_msg(input logic [31:0] m);
    up_q.push_back(m);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), m[i*8 +: 8]});
  endtask

  // One clock: drive at negedge, sample 1 time unit later, act on the following posedge.
  task automatic step();
    logic [8:0]  e;
    logic [31:0] d;
    @(negedge clk);
    reset     = rst_v;
    q.enq_rdy = rdy_v;
    q.deq_rdy = up_en && (up_q.size() != 0);
    q.deq_msg = (up_q.size() != 0) ? up_q[0] : 32'h0;
    #1;
    s_deq_en   = q.deq_en;
    s_deq_rdy  = q.deq_rdy;
    s_enq_en   = q.enq_en;
    s_enq_msg  = q.enq_msg;
    s_enq_last = q.enq_last;
    s_busy     = busy;
    check("deq_en_rule", {31'b0, s_deq_en & ~s_deq_rdy}, 32'd0);
    check("enq_en_rule", {31'b0, s_enq_en & ~q.enq_rdy}, 32'd0);
    if (s_enq_en) begin
      flits_seen++;
      last_flit = s_enq_msg;
      if (flits_seen == 1) first_flit = s_enq_msg;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got flit %0h expected none (cycle %0d)", s_enq_msg, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_flit", {24'b0, s_enq_msg}, {24'b0, e[7:0]});
        check("sb_last", {31'b0, s_enq_last}, {31'b0, e[8]});
      end
    end
    @(posedge clk);
    if (s_deq_en && (up_q.size() != 0)) d = up_q.pop_front();
    cyc++;
  endtask

  task automatic wait_flits(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (flits_seen < n && k < budget) begin
      step();
      k++;
    end
    check(name, {31'b0, (flits_seen >= n)}, 32'd1);
  endtask

  vec_t vt[14];

  initial begin
    int f_first, f_last, coincide;

    // rows 0-5: single message; rows 6-13: same message with enq_rdy low for two cycles
`ifdef SERIALIZER_BYPASS_EN
    vt[0]  = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
`else
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
`endif

    reset     = 1'b1;
    q.deq_rdy = 1'b0;
    q.deq_msg = '0;
    q.enq_rdy = 1'b0;

    // Reset: a waiting message and a ready sink must not produce any handshake
    up_q.push_back(32'h12345678);
    step();
    step();
    check("rst_deq_en", {31'b0, s_deq_en}, 32'd0);
    check("rst_enq_en", {31'b0, s_enq_en}, 32'd0);
    check("rst_enq_msg", {24'b0, s_enq_msg}, 32'd0);
    check("rst_enq_last", {31'b0, s_enq_last}, 32'd0);
    check("rst_busy", {31'b0, s_busy}, 32'd0);
    up_q.delete();
    rst_v = 1'b0;

    // Upstream empty for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_deq_en", {31'b0, s_deq_en}, 32'd0);
      check("idle_enq_en", {31'b0, s_enq_en}, 32'd0);
      check("idle_busy", {31'b0, s_busy}, 32'd0);
    end

    // Table: single message, then stalled message
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || i == 6) push_msg(32'hDDCCBBAA);
      rdy_v = vt[i].enq_rdy;
      step();
      check($sformatf("vec%0d_deq_en", i), {31'b0, s_deq_en}, {31'b0, vt[i].deq_en});
      check($sformatf("vec%0d_enq_en", i), {31'b0, s_enq_en}, {31'b0, vt[i].enq_en});
      check($sformatf("vec%0d_enq_msg", i), {24'b0, s_enq_msg}, {24'b0, vt[i].msg});
      check($sformatf("vec%0d_enq_last", i), {31'b0, s_enq_last}, {31'b0, vt[i].last});
      check($sformatf("vec%0d_busy", i), {31'b0, s_busy}, {31'b0, vt[i].busy});
    end
    rdy_v = 1'b1;
    check("tbl_drained", exp_q.size(), 32'd0);

    // Two queued messages: 8 back-to-back flits, reload coincides with flit 03
    push_msg(32'h03020100);
    push_msg(32'h07060504);
    flits_seen = 0;
    f_first = -1;
    f_last = -1;
    coincide = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (s_enq_en) begin
        if (f_first < 0) f_first = cyc;
        f_last = cyc;
      end
      if (s_deq_en && s_enq_en && s_enq_msg == 8'h03) coincide++;
    end
    check("b2b_flits", flits_seen, 32'd8);
    check("b2b_span", f_last - f_first, 32'd7);
    check("b2b_reload_at_03", coincide, 32'd1);

    // Reset after two flits: partial message dropped, next message starts at flit 0
    push_msg(32'hDDCCBBAA);
    flits_seen = 0;
    wait_flits(2, 10, "pre_reset_flits");
    rst_v = 1'b1;
    step();
    check("midrst_enq_en", {31'b0, s_enq_en}, 32'd0);
    check("midrst_busy", {31'b0, s_busy}, 32'd0);
    exp_q.delete();
    up_q.delete();
    rst_v = 1'b0;
    step();
    check("postrst_busy", {31'b0, s_busy}, 32'd0);
    check("postrst_enq_en", {31'b0, s_enq_en}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("postrst_no_flits", flits_seen, 32'd2);
    flits_seen = 0;
    push_msg(32'h44332211);
    wait_flits(4, 12, "postrst_msg_done");
    check("postrst_first_flit", {24'b0, first_flit}, 32'h11);
    check("postrst_last_flit", {24'b0, last_flit}, 32'h44);

    // Random back-pressure on both sides
    for (int i = 0; i < 6; i++) push_msg($urandom);
    flits_seen = 0;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      rdy_v = ($urandom_range(0, 3) != 0);
      up_en = ($urandom_range(0, 2) != 0);
      step();
    end
    rdy_v = 1'b1;
    up_en = 1'b1;
    check("rand_drained", exp_q.size(), 32'd0);
    check("rand_flits", flits_seen, 32'd24);
    for (int i = 0; i < 3; i++) step();
    check("rand_idle_busy", {31'b0, s_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
